// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO: state encodings and default geometry.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_ADDR_W = 3;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_NO_OP    = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_WR_ERROR = 3'd3;
    localparam logic [2:0] ST_READ     = 3'd4;
    localparam logic [2:0] ST_RD_ERROR = 3'd5;

    typedef enum logic [2:0] {
        INIT     = ST_INIT,
        NO_OP    = ST_NO_OP,
        WRITE    = ST_WRITE,
        WR_ERROR = ST_WR_ERROR,
        READ     = ST_READ,
        RD_ERROR = ST_RD_ERROR
    } state_e;

endpackage

// File: rtl/fifo_ns.sv
// Combinational next-state, next-pointer and next-count decode for fifo32.
module fifo_ns
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] head,
    input  logic [ADDR_W-1:0] tail,
    input  logic [ADDR_W:0]   count,
    output state_e            next_state_c,
    output logic [ADDR_W-1:0] head_nxt_c,
    output logic [ADDR_W-1:0] tail_nxt_c,
    output logic [ADDR_W:0]   count_nxt_c,
    output logic              mem_we_c,
    output logic              mem_re_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic full_c;
    logic empty_c;

    assign full_c  = (count == (ADDR_W + 1)'(DEPTH));
    assign empty_c = (count == '0);

    // Priority: reset > simultaneous request > write > read > idle.
    always_comb begin
        next_state_c = NO_OP;
        head_nxt_c   = head;
        tail_nxt_c   = tail;
        count_nxt_c  = count;
        mem_we_c     = 1'b0;
        mem_re_c     = 1'b0;

        if (reset) begin
            next_state_c = INIT;
            head_nxt_c   = '0;
            tail_nxt_c   = '0;
            count_nxt_c  = '0;
        end else if (wr_en && rd_en) begin
            next_state_c = NO_OP;
        end else if (wr_en) begin
            if (full_c) begin
                next_state_c = WR_ERROR;
            end else begin
                next_state_c = WRITE;
                mem_we_c     = 1'b1;
                tail_nxt_c   = tail + ADDR_W'(1);
                count_nxt_c  = count + (ADDR_W + 1)'(1);
            end
        end else if (rd_en) begin
            if (empty_c) begin
                next_state_c = RD_ERROR;
            end else begin
                next_state_c = READ;
                mem_re_c     = 1'b1;
                head_nxt_c   = head + ADDR_W'(1);
                count_nxt_c  = count - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/fifo32.sv
// 8-deep synchronous FIFO with registered read data and per-request ack/error flags.
module fifo32
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  d_out,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [ADDR_W:0]   data_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e            state;
    state_e            next_state_c;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W-1:0] head_nxt_c;
    logic [ADDR_W-1:0] tail_nxt_c;
    logic [ADDR_W:0]   count_nxt_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic [WIDTH-1:0]  mem [DEPTH];

    fifo_ns #(
        .ADDR_W (ADDR_W)
    ) u_ns (
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .head         (head),
        .tail         (tail),
        .count        (data_count),
        .next_state_c (next_state_c),
        .head_nxt_c   (head_nxt_c),
        .tail_nxt_c   (tail_nxt_c),
        .count_nxt_c  (count_nxt_c),
        .mem_we_c     (mem_we_c),
        .mem_re_c     (mem_re_c)
    );

    // State, pointer, count and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            head       <= '0;
            tail       <= '0;
            data_count <= '0;
            d_out      <= '0;
        end else begin
            state      <= next_state_c;
            head       <= head_nxt_c;
            tail       <= tail_nxt_c;
            data_count <= count_nxt_c;
            if (mem_re_c) begin
                d_out <= mem[head];
            end
        end
    end

    // Storage has no reset; a word is only read after it has been written.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[tail] <= d_in;
        end
    end

    // Flags are pure decodes of the state register, so each lasts one cycle per request.
    assign wr_ack = (state == WRITE);
    assign wr_err = (state == WR_ERROR);
    assign rd_ack = (state == READ);
    assign rd_err = (state == RD_ERROR);

    assign full  = (data_count == (ADDR_W + 1)'(DEPTH));
    assign empty = (data_count == '0);

endmodule

// File: tb/tb_fifo32.sv
// Self-checking bench for fifo32 against a queue-based reference model.
module tb_fifo32;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] d_in;
    logic        rd_en;
    logic [31:0] d_out;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [3:0]  data_count;

    fifo32 dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .d_in       (d_in),
        .rd_en      (rd_en),
        .d_out      (d_out),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus last read word and flags.
    logic [31:0] q[$];
    logic [31:0] m_dout;
    logic        m_wack, m_werr, m_rack, m_rerr;

    int pass_cnt = 0;
    int total    = 0;

    function automatic logic [41:0] obs_v();
        return {d_out, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err};
    endfunction

    function automatic logic [41:0] exp_v();
        return {m_dout, 4'(q.size()), q.size() == 8, q.size() == 0,
                m_wack, m_werr, m_rack, m_rerr};
    endfunction

    // Apply one edge of stimulus and advance the model; outputs sampled 1ns after the edge.
    task automatic cycle(input logic r, input logic w, input logic rd, input logic [31:0] d);
        reset = r;
        wr_en = w;
        rd_en = rd;
        d_in  = d;
        @(posedge clk);
        m_wack = 1'b0;
        m_werr = 1'b0;
        m_rack = 1'b0;
        m_rerr = 1'b0;
        if (r) begin
            q.delete();
            m_dout = '0;
        end else if (w && rd) begin
            // simultaneous requests are ignored
        end else if (w) begin
            if (q.size() == 8) m_werr = 1'b1;
            else begin
                q.push_back(d);
                m_wack = 1'b1;
            end
        end else if (rd) begin
            if (q.size() == 0) m_rerr = 1'b1;
            else begin
                m_dout = q.pop_front();
                m_rack = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'hdead_beef);
        total++;
        if (obs_v() !== 42'({32'h0, 4'd0, 1'b0, 1'b1, 4'b0000})) $display("FAIL reset_state got=%h exp=%h", obs_v(), 42'({32'h0, 4'd0, 1'b0, 1'b1, 4'b0000}));
        else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if ({rd_err, empty, data_count, d_out} !== {1'b1, 1'b1, 4'd0, 32'h0}) $display("FAIL empty_read rd_err=%b empty=%b cnt=%0d d_out=%h exp 1 1 0 0", rd_err, empty, data_count, d_out);
        else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (rd_err !== 1'b0) $display("FAIL rd_err_one_cycle got=%b exp=0", rd_err);
        else pass_cnt++;
    endtask

    task automatic test_order();
        logic [31:0] words [3];
        words[0] = 32'h2019_0923;
        words[1] = 32'h1234_5678;
        words[2] = 32'h8765_4321;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, words[i]);
            total++;
            if ({wr_ack, data_count} !== {1'b1, 4'(i + 1)}) $display("FAIL order_write%0d ack=%b cnt=%0d exp ack=1 cnt=%0d", i, wr_ack, data_count, i + 1);
            else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if ({rd_ack, d_out} !== {1'b1, words[i]}) $display("FAIL order_read%0d ack=%b d_out=%h exp ack=1 d_out=%h", i, rd_ack, d_out, words[i]);
            else pass_cnt++;
        end
        total++;
        if ({data_count, empty} !== {4'd0, 1'b1}) $display("FAIL order_drained cnt=%0d empty=%b exp 0 1", data_count, empty);
        else pass_cnt++;
    endtask

    task automatic test_full();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, $urandom() & 32'h7fff_ffff);
        total++;
        if ({full, data_count, wr_ack} !== {1'b1, 4'd8, 1'b1}) $display("FAIL full_after8 full=%b cnt=%0d ack=%b exp 1 8 1", full, data_count, wr_ack);
        else pass_cnt++;
        cycle(1'b0, 1'b1, 1'b0, 32'hffff_ffff);
        total++;
        if ({wr_err, wr_ack, data_count, full} !== {1'b1, 1'b0, 4'd8, 1'b1}) $display("FAIL overflow err=%b ack=%b cnt=%0d full=%b exp 1 0 8 1", wr_err, wr_ack, data_count, full);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if (obs_v() !== exp_v() || d_out === 32'hffff_ffff) $display("FAIL full_drain%0d got=%h exp=%h", i, obs_v(), exp_v());
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, $urandom());
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, $urandom());
        total++;
        if (obs_v() !== exp_v() || data_count !== 4'd8) $display("FAIL wrap_refill got=%h exp=%h", obs_v(), exp_v());
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if (obs_v() !== exp_v()) $display("FAIL wrap_read%0d got=%h exp=%h", i, obs_v(), exp_v());
            else pass_cnt++;
        end
    endtask

    task automatic test_both();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, $urandom());
        cycle(1'b0, 1'b1, 1'b1, 32'h5555_aaaa);
        total++;
        if ({data_count, wr_ack, wr_err, rd_ack, rd_err} !== {4'd3, 4'b0000}) $display("FAIL both_req cnt=%0d flags=%b%b%b%b exp cnt=3 flags=0000", data_count, wr_ack, wr_err, rd_ack, rd_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, $urandom());
        total++;
        if (data_count !== 4'd4) $display("FAIL mid_pre cnt=%0d exp=4", data_count);
        else pass_cnt++;
        cycle(1'b1, 1'b1, 1'b0, 32'h0bad_0bad);
        total++;
        if ({data_count, empty, wr_ack, d_out} !== {4'd0, 1'b1, 1'b0, 32'h0}) $display("FAIL mid_reset cnt=%0d empty=%b ack=%b d_out=%h exp 0 1 0 0", data_count, empty, wr_ack, d_out);
        else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if (obs_v() !== exp_v()) $display("FAIL mid_after got=%h exp=%h", obs_v(), exp_v());
        else pass_cnt++;
    endtask

    task automatic test_random();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic r, w, rd;
            r  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 99) < (i < 200 ? 65 : 35));
            rd = ($urandom_range(0, 99) < (i < 200 ? 35 : 65));
            cycle(r, w, rd, $urandom());
            total++;
            if (obs_v() !== exp_v()) $display("FAIL random%0d got=%h exp=%h", i, obs_v(), exp_v());
            else pass_cnt++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        d_in   = '0;
        m_dout = '0;
        m_wack = 1'b0;
        m_werr = 1'b0;
        m_rack = 1'b0;
        m_rerr = 1'b0;
        test_reset();
        test_order();
        test_full();
        test_wrap();
        test_both();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
